alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execution stage directly downstream of the ALU reservation station.
- Accepts one issued operation per handshake: opcode, two operand values and the destination ROB index.
- Computes the result; MUL is multi-cycle.
- Holds the result in an output register until the CDB arbiter grants the bus, then broadcasts on the CDB (cdb_en/cdb_rob_idx/cdb_val) and drives the alu_busy back-pressure to the station.

Parameters:
- DATA_W, 3: operand/result width.
- ROB_W, 2: ROB index width.
- MUL_LAT, 3: total cycles from accept to result-valid for MUL. Legal range 2..7.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  station has a ready entry (connects to rs_ready)
- issue_opcode  in  3  operation code
- issue_val1  in  DATA_W  operand A
- issue_val2  in  DATA_W  operand B
- issue_rob_idx  in  ROB_W  destination ROB tag
- flush  in  1  pipeline flush; kills in-flight op
- cdb_grant  in  1  arbiter grants CDB this cycle
- alu_busy  out  1  registered; high when not IDLE
- cdb_req  out  1  result waiting for the bus
- cdb_en  out  1  broadcast strobe (cdb_req & cdb_grant)
- cdb_rob_idx  out  ROB_W  tag of broadcast result
- cdb_val  out  DATA_W  broadcast result

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, alu_busy=0, cdb_req=0.
  - Result/tag registers and cycle counter = 0; cdb_en=0, cdb_rob_idx=0, cdb_val=0.
- alu_busy is a pure function of registered state (high in EXEC and WB). It never depends combinationally on issue_* or cdb_grant, so the station's alu_busy -> rs_ready path has no loop.
- Accept: in IDLE with issue_valid=1 and flush=0, capture opcode/vals/tag on that edge. The station retires its entry in the same cycle, so accept is unconditional. issue_valid while alu_busy=1 is a protocol error; ignore it and raise an assertion in the bench.
- Opcodes, all results mod 2^DATA_W:
  - 0 ADD: a+b
  - 1 SUB: a-b, wraps
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL: a<<b; 0 if b>=DATA_W
  - 6 SHR: logical a>>b; 0 if b>=DATA_W
  - 7 MUL: low DATA_W bits of a*b
- FSM:
  - IDLE -> WB on accept of a non-MUL op; result registered at the accept edge, cdb_req high the next cycle.
  - IDLE -> EXEC on accept of MUL; counter loaded with MUL_LAT-2.
  - EXEC: counter decrements each cycle. At counter==0, register the result and go to WB; cdb_req rises exactly MUL_LAT cycles after the accept edge, counting the accept-to-next-cycle as 1.
  - WB: cdb_req=1; cdb_en=cdb_grant (combinational); cdb_rob_idx/cdb_val are stable from the registers. Grant -> IDLE on that edge. No grant -> stay in WB, outputs held unchanged indefinitely.
- Throughput: single-cycle ops reach at most 1 result per 2 cycles (accept, WB); back-to-back accept the cycle after a granted WB is allowed.
- cdb_rob_idx/cdb_val are driven 0 when cdb_req=0.
- flush: any state -> IDLE next edge. cdb_req and cdb_en are forced 0 in the flush cycle even if granted. An accept in the same cycle as flush is dropped.
- cdb_grant while cdb_req=0: ignored, cdb_en=0.
- Reset mid-EXEC or mid-WB: immediate return to reset values; no broadcast.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum (ADD..MUL, 3 bits)
  - DATA_W/ROB_W localparams
  - exec_state_e (IDLE, EXEC, WB)
  - rs_issue_t packed struct (opcode, val1, val2, rob_idx), reusable by the station.
- One sub-module, alu_core: purely combinational opcode/operand -> result, instantiated once.
- FSM, counter and output registers live in alu_exec_unit.

Test Plan:
- ADD 5+6, tag 2, grant held high -> cdb_req rises 1 cycle after accept; cdb_en=1, cdb_rob_idx=2, cdb_val=3 (wrap); alu_busy low the following cycle.
- MUL 3*3, tag 1, MUL_LAT=3 -> alu_busy high for 3 cycles; cdb_req rises 3 cycles after accept; cdb_val=1; tag 1.
- SUB 2-5 with grant withheld 4 cycles -> cdb_req stays 1, cdb_val=5 stable, cdb_en=0; broadcasts on the first grant cycle, then IDLE.
- SHL 3<<4 and SHR 7>>1 back-to-back -> results 0 then 3; second accept occurs the cycle after the first grant.
- flush during MUL EXEC cycle 2 -> no cdb_req/cdb_en ever; alu_busy=0 next cycle; a new ADD 1+1 is then accepted, giving cdb_val=2.
- rst_n asserted asynchronously while in WB with grant=0 -> all outputs 0 immediately; after release, a fresh ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU execution stage and the reservation station feeding it.
package alu_pkg;

    localparam int unsigned DATA_W = 3;
    localparam int unsigned ROB_W  = 2;
    localparam int unsigned OPC_W  = 3;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } exec_state_e;

    typedef struct packed {
        alu_op_e             opcode;
        logic [DATA_W-1:0]   val1;
        logic [DATA_W-1:0]   val2;
        logic [ROB_W-1:0]    rob_idx;
    } rs_issue_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: opcode and operands to a DATA_W-bit result.
module alu_core
    import alu_pkg::*;
(
    input  alu_op_e           opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result_c
);

    localparam int unsigned          PROD_W    = 2 * DATA_W;
    localparam logic [DATA_W-1:0]    SHAMT_LIM = DATA_W'(DATA_W);

    logic [PROD_W-1:0] prod;
    logic              shift_oob;

    assign prod      = PROD_W'(a) * PROD_W'(b);
    assign shift_oob = (b >= SHAMT_LIM);

    always_comb begin
        result_c = '0;
        case (opcode)
            OP_ADD: result_c = a + b;
            OP_SUB: result_c = a - b;
            OP_AND: result_c = a & b;
            OP_OR:  result_c = a | b;
            OP_XOR: result_c = a ^ b;
            OP_SHL: result_c = shift_oob ? '0 : (a << b);
            OP_SHR: result_c = shift_oob ? '0 : (a >> b);
            OP_MUL: result_c = prod[DATA_W-1:0];
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution stage: accepts one issued op, computes it (MUL is multi-cycle),
// then holds the result until the CDB arbiter grants the bus.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [OPC_W-1:0]  issue_opcode,
    input  logic [DATA_W-1:0] issue_val1,
    input  logic [DATA_W-1:0] issue_val2,
    input  logic [ROB_W-1:0]  issue_rob_idx,
    input  logic              flush,
    input  logic              cdb_grant,
    output logic              alu_busy,
    output logic              cdb_req,
    output logic              cdb_en,
    output logic [ROB_W-1:0]  cdb_rob_idx,
    output logic [DATA_W-1:0] cdb_val
);

    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 2);

    exec_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    rs_issue_t         pkt_q, pkt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              busy_q;

    rs_issue_t         issue_pkt;
    rs_issue_t         core_src;
    logic [DATA_W-1:0] core_res;

    assign issue_pkt = '{
        opcode:  alu_op_e'(issue_opcode),
        val1:    issue_val1,
        val2:    issue_val2,
        rob_idx: issue_rob_idx
    };

    // In IDLE the core sees the live issue bus; otherwise the captured op.
    assign core_src = (state_q == IDLE) ? issue_pkt : pkt_q;

    alu_core u_alu_core (
        .opcode   (core_src.opcode),
        .a        (core_src.val1),
        .b        (core_src.val2),
        .result_c (core_res)
    );

    // Next-state and datapath-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pkt_d   = pkt_q;
        res_d   = res_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_valid) begin
                        pkt_d = issue_pkt;
                        if (issue_pkt.opcode == OP_MUL) begin
                            cnt_d   = MUL_CNT_INIT;
                            state_d = EXEC;
                        end else begin
                            res_d   = core_res;
                            state_d = WB;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        res_d   = core_res;
                        state_d = WB;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                WB: begin
                    if (cdb_grant) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pkt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pkt_q   <= pkt_d;
            res_q   <= res_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Busy comes straight from a flop so the station's ready path has no loop.
    assign alu_busy    = busy_q;
    assign cdb_req     = (state_q == WB) && !flush;
    assign cdb_en      = cdb_req && cdb_grant;
    assign cdb_rob_idx = cdb_req ? pkt_q.rob_idx : '0;
    assign cdb_val     = cdb_req ? res_q : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a scoreboard of expected CDB broadcasts.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              issue_valid;
    logic [OPC_W-1:0]  issue_opcode;
    logic [DATA_W-1:0] issue_val1;
    logic [DATA_W-1:0] issue_val2;
    logic [ROB_W-1:0]  issue_rob_idx;
    logic              flush;
    logic              cdb_grant;
    logic              alu_busy;
    logic              cdb_req;
    logic              cdb_en;
    logic [ROB_W-1:0]  cdb_rob_idx;
    logic [DATA_W-1:0] cdb_val;

    typedef struct packed {
        logic [ROB_W-1:0]  idx;
        logic [DATA_W-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    alu_exec_unit #(.MUL_LAT(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_opcode  (issue_opcode),
        .issue_val1    (issue_val1),
        .issue_val2    (issue_val2),
        .issue_rob_idx (issue_rob_idx),
        .flush         (flush),
        .cdb_grant     (cdb_grant),
        .alu_busy      (alu_busy),
        .cdb_req       (cdb_req),
        .cdb_en        (cdb_en),
        .cdb_rob_idx   (cdb_rob_idx),
        .cdb_val       (cdb_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] model(input int op, input int a, input int b);
        int r;
        int m;
        m = 1 << DATA_W;
        case (op)
            0: r = a + b;
            1: r = a - b + m;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (b >= int'(DATA_W)) ? 0 : a * (1 << b);
            6: r = (b >= int'(DATA_W)) ? 0 : a / (1 << b);
            7: r = a * b;
            default: r = 0;
        endcase
        return DATA_W'(r % m);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic busy, input logic req, input logic en,
                           input logic [ROB_W-1:0] idx, input logic [DATA_W-1:0] val);
        check({tag, ".alu_busy"},    32'(alu_busy),    32'(busy));
        check({tag, ".cdb_req"},     32'(cdb_req),     32'(req));
        check({tag, ".cdb_en"},      32'(cdb_en),      32'(en));
        check({tag, ".cdb_rob_idx"}, 32'(cdb_rob_idx), 32'(idx));
        check({tag, ".cdb_val"},     32'(cdb_val),     32'(val));
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic issue(input int op, input int a, input int b, input int tag, input bit expect_bc);
        exp_t e;
        issue_valid   = 1'b1;
        issue_opcode  = OPC_W'(op);
        issue_val1    = DATA_W'(a);
        issue_val2    = DATA_W'(b);
        issue_rob_idx = ROB_W'(tag);
        if (expect_bc) begin
            e.idx = ROB_W'(tag);
            e.val = model(op, a, b);
            sb.push_back(e);
        end
    endtask

    // Scoreboard: every broadcast must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && cdb_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb.unexpected: observed broadcast idx=%0h val=%0h expected none",
                       cdb_rob_idx, cdb_val);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb.idx", 32'(cdb_rob_idx), 32'(e.idx));
                check("sb.val", 32'(cdb_val),     32'(e.val));
            end
        end
    end

    // Protocol: the bench must never offer an op while the unit is busy.
    always @(negedge clk) begin
        if (rst_n && issue_valid) begin
            checks++;
            assert (alu_busy === 1'b0) else begin
                errors++;
                $error("FAIL protocol: observed alu_busy=%0b with issue_valid expected 0", alu_busy);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        issue_valid   = 1'b0;
        issue_opcode  = '0;
        issue_val1    = '0;
        issue_val2    = '0;
        issue_rob_idx = '0;
        flush         = 1'b0;
        cdb_grant     = 1'b1;

        // Reset state, grant ignored while nothing is pending
        samp();
        samp();
        chk_out("reset", 1'b0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;

        // ADD 5+6 tag 2 with grant held
        next(); issue(0, 5, 6, 2, 1'b1);
        samp(); chk_out("add.pre", 1'b0, 1'b0, 1'b0, '0, '0);
        next(); issue_valid = 1'b0;
        samp(); chk_out("add.wb", 1'b1, 1'b1, 1'b1, 2'd2, 3'd3);
        next();
        samp(); chk_out("add.idle", 1'b0, 1'b0, 1'b0, '0, '0);

        // MUL 3*3 tag 1: two EXEC cycles then WB
        next(); issue(7, 3, 3, 1, 1'b1);
        samp();
        next(); issue_valid = 1'b0;
        samp(); chk_out("mul.exec1", 1'b1, 1'b0, 1'b0, '0, '0);
        next();
        samp(); chk_out("mul.exec2", 1'b1, 1'b0, 1'b0, '0, '0);
        next();
        samp(); chk_out("mul.wb", 1'b1, 1'b1, 1'b1, 2'd1, 3'd1);
        next();
        samp(); chk_out("mul.idle", 1'b0, 1'b0, 1'b0, '0, '0);

        // SUB 2-5 tag 3 with grant withheld four cycles
        cdb_grant = 1'b0;
        next(); issue(1, 2, 5, 3, 1'b1);
        samp();
        next(); issue_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            samp(); chk_out("sub.hold", 1'b1, 1'b1, 1'b0, 2'd3, 3'd5);
            next();
        end
        cdb_grant = 1'b1;
        samp(); chk_out("sub.grant", 1'b1, 1'b1, 1'b1, 2'd3, 3'd5);
        next();
        samp(); chk_out("sub.idle", 1'b0, 1'b0, 1'b0, '0, '0);

        // SHL 3<<4 then SHR 7>>1 back-to-back
        next(); issue(5, 3, 4, 0, 1'b1);
        samp();
        next(); issue_valid = 1'b0;
        samp(); chk_out("shl.wb", 1'b1, 1'b1, 1'b1, 2'd0, 3'd0);
        next(); issue(6, 7, 1, 1, 1'b1);
        samp(); chk_out("shr.accept", 1'b0, 1'b0, 1'b0, '0, '0);
        next(); issue_valid = 1'b0;
        samp(); chk_out("shr.wb", 1'b1, 1'b1, 1'b1, 2'd1, 3'd3);
        next();
        samp(); chk_out("shr.idle", 1'b0, 1'b0, 1'b0, '0, '0);

        // Flush in MUL EXEC cycle 2: never broadcasts
        next(); issue(7, 2, 3, 2, 1'b0);
        samp();
        next(); issue_valid = 1'b0;
        samp(); chk_out("flmul.exec1", 1'b1, 1'b0, 1'b0, '0, '0);
        next(); flush = 1'b1;
        samp(); chk_out("flmul.exec2", 1'b1, 1'b0, 1'b0, '0, '0);
        next(); flush = 1'b0;
        samp(); chk_out("flmul.idle", 1'b0, 1'b0, 1'b0, '0, '0);
        next();
        samp(); chk_out("flmul.quiet", 1'b0, 1'b0, 1'b0, '0, '0);

        // ADD 1+1 tag 3 after the flush
        next(); issue(0, 1, 1, 3, 1'b1);
        samp();
        next(); issue_valid = 1'b0;
        samp(); chk_out("add2.wb", 1'b1, 1'b1, 1'b1, 2'd3, 3'd2);
        next();
        samp(); chk_out("add2.idle", 1'b0, 1'b0, 1'b0, '0, '0);

        // Flush in WB while granted: request and strobe suppressed
        cdb_grant = 1'b0;
        next(); issue(3, 3, 4, 1, 1'b0);
        samp();
        next(); issue_valid = 1'b0; flush = 1'b1; cdb_grant = 1'b1;
        samp(); chk_out("flwb.flush", 1'b1, 1'b0, 1'b0, '0, '0);
        next(); flush = 1'b0;
        samp(); chk_out("flwb.idle", 1'b0, 1'b0, 1'b0, '0, '0);

        // Accept coinciding with flush is dropped
        next(); issue(4, 5, 2, 0, 1'b0); flush = 1'b1;
        samp(); chk_out("flacc.same", 1'b0, 1'b0, 1'b0, '0, '0);
        next(); issue_valid = 1'b0; flush = 1'b0;
        samp(); chk_out("flacc.after", 1'b0, 1'b0, 1'b0, '0, '0);

        // Async reset while waiting in WB without grant
        cdb_grant = 1'b0;
        next(); issue(2, 6, 3, 2, 1'b0);
        samp();
        next(); issue_valid = 1'b0;
        samp(); chk_out("rst.wb", 1'b1, 1'b1, 1'b0, 2'd2, 3'd2);
        #2 rst_n = 1'b0;
        #1 chk_out("rst.async", 1'b0, 1'b0, 1'b0, '0, '0);
        samp(); rst_n = 1'b1;
        cdb_grant = 1'b1;
        next(); issue(0, 4, 2, 1, 1'b1);
        samp(); chk_out("rst.fresh_pre", 1'b0, 1'b0, 1'b0, '0, '0);
        next(); issue_valid = 1'b0;
        samp(); chk_out("rst.fresh_wb", 1'b1, 1'b1, 1'b1, 2'd1, 3'd6);
        next();
        samp(); chk_out("rst.fresh_idle", 1'b0, 1'b0, 1'b0, '0, '0);

        repeat (2) samp();
        check("sb.drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
